// File: rtl/lc3_pkg.sv
// Shared LC-3 constants and types used by the branch resolution logic.
package lc3_pkg;

    localparam int WORD_W = 16;
    localparam logic [3:0] OP_BR = 4'b0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        RESOLVE = 2'd3
    } branch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target generation: incremented PC plus sign-extended 9-bit offset.
module branch_target_adder
    import lc3_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [8:0]        offset,
    output logic [WORD_W-1:0] target
);

    // 16-bit modulo add; wrap-around is the architectural behaviour.
    assign target = pc + {{(WORD_W-9){offset[8]}}, offset};

endmodule

// File: rtl/branch_ctrl.sv
// BR resolution sequencer: pulses LDBEN, samples BEN, issues the PC load strobe
// and keeps saturating branch/taken counters.
module branch_ctrl
    import lc3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] ir,
    input  logic [WORD_W-1:0] pc_in,
    input  logic              ben,
    output logic              ldben,
    output logic [2:0]        ir_nzp,
    output logic              ld_pc,
    output logic [WORD_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    branch_state_t      state_q, state_d;
    logic [2:0]         nzp_q;
    logic [8:0]         off_q;
    logic [WORD_W-1:0]  pc_q;
    logic [WORD_W-1:0]  target;
    logic               ldben_q, ld_pc_q, done_q, illegal_q;
    logic [WORD_W-1:0]  pc_out_q;
    logic [CNT_W-1:0]   branch_cnt_q, taken_cnt_q;
    logic               accept, reject, resolve_now, taken_now;

    branch_target_adder u_target (
        .pc     (pc_q),
        .offset (off_q),
        .target (target)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        reject      = 1'b0;
        resolve_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ir[15:12] == OP_BR) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOAD:    state_d = WAIT;
            // BEN is valid during WAIT; it is captured on the edge into RESOLVE
            // so that ld_pc and done are plain register outputs.
            WAIT: begin
                resolve_now = 1'b1;
                state_d     = RESOLVE;
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        taken_now = resolve_now & ben;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            nzp_q        <= 3'b000;
            off_q        <= 9'd0;
            pc_q         <= '0;
            ldben_q      <= 1'b0;
            ld_pc_q      <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            pc_out_q     <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ldben_q   <= accept;
            illegal_q <= reject;
            done_q    <= resolve_now;
            ld_pc_q   <= taken_now;
            if (accept) begin
                nzp_q <= ir[11:9];
                off_q <= ir[8:0];
                pc_q  <= pc_in;
            end
            if (taken_now) begin
                pc_out_q <= target;
            end
            if (resolve_now && branch_cnt_q != CNT_MAX) begin
                branch_cnt_q <= branch_cnt_q + CNT_ONE;
            end
            if (taken_now && taken_cnt_q != CNT_MAX) begin
                taken_cnt_q <= taken_cnt_q + CNT_ONE;
            end
        end
    end

    assign ldben        = ldben_q;
    assign ir_nzp       = nzp_q;
    assign ld_pc        = ld_pc_q;
    assign pc_out       = pc_out_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign branch_count = branch_cnt_q;
    assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: drivers push expected responses, a negedge
// monitor pops them on done/illegal and compares.
module tb_branch_ctrl;

    localparam int EXP_W = 66;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic [15:0] pc_in = '0;
    logic [2:0]  cc = 3'b000;
    logic        ben, ben_sat;
    logic        ldben, ld_pc, busy, done, illegal;
    logic [2:0]  ir_nzp;
    logic [15:0] pc_out;
    logic [7:0]  branch_count, taken_count;

    logic        s_ldben, s_ld_pc, s_busy, s_done, s_illegal;
    logic [2:0]  s_ir_nzp;
    logic [15:0] s_pc_out;
    logic [1:0]  s_branch_count, s_taken_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ldben_cnt = 0;
    int ldben_cyc = 0;
    logic [7:0] model_b = '0;
    logic [7:0] model_t = '0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    // Condition-code block model: BEN = |(captured nzp & current N/Z/P).
    assign ben     = |(ir_nzp & cc);
    assign ben_sat = |(s_ir_nzp & cc);

    branch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ir(ir), .pc_in(pc_in), .ben(ben),
        .ldben(ldben), .ir_nzp(ir_nzp), .ld_pc(ld_pc), .pc_out(pc_out), .busy(busy),
        .done(done), .illegal(illegal), .branch_count(branch_count), .taken_count(taken_count)
    );

    branch_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .ir(ir), .pc_in(pc_in), .ben(ben_sat),
        .ldben(s_ldben), .ir_nzp(s_ir_nzp), .ld_pc(s_ld_pc), .pc_out(s_pc_out), .busy(s_busy),
        .done(s_done), .illegal(s_illegal), .branch_count(s_branch_count), .taken_count(s_taken_count)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ldben"}, 32'(ldben), 0);
        check({tag, "_ld_pc"}, 32'(ld_pc), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_illegal"}, 32'(illegal), 0);
        check({tag, "_pc_out"}, 32'(pc_out), 0);
        check({tag, "_ir_nzp"}, 32'(ir_nzp), 0);
        check({tag, "_branch_count"}, 32'(branch_count), 0);
        check({tag, "_taken_count"}, 32'(taken_count), 0);
    endtask

    // driver: raise start for one cycle and push the expected response
    task automatic issue(input logic [15:0] i, input logic [15:0] p, input logic [2:0] c,
                         input logic exp_taken, input logic [15:0] exp_pc);
        logic [3:0] op;
        @(negedge clk);
        ir = i; pc_in = p; cc = c; start = 1'b1;
        op = i[15:12];
        if (op == 4'b0000) begin
            if (model_b != 8'hFF) model_b = model_b + 8'd1;
            if (exp_taken && model_t != 8'hFF) model_t = model_t + 8'd1;
            exp_q.push_back({1'b0, exp_taken, exp_pc, model_b, model_t, 32'(cyc)});
        end else begin
            exp_q.push_back({1'b1, 1'b0, 16'h0000, model_b, model_t, 32'(cyc)});
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // monitor
    always @(negedge clk) begin
        if (reset) begin
            ldben_cnt = 0;
        end else begin
            if (ldben) begin
                ldben_cnt = ldben_cnt + 1;
                ldben_cyc = cyc;
            end
            if (ld_pc && !done) check("ld_pc_without_done", 32'(ld_pc), 0);
            if (done || illegal) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'({done, illegal}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_kind", 32'(illegal), 32'(mon_e[65]));
                    if (done) begin
                        check("ld_pc", 32'(ld_pc), 32'(mon_e[64]));
                        if (mon_e[64]) check("pc_out", 32'(pc_out), 32'(mon_e[63:48]));
                        check("branch_count", 32'(branch_count), 32'(mon_e[47:40]));
                        check("taken_count", 32'(taken_count), 32'(mon_e[39:32]));
                        check("done_latency", 32'(cyc) - mon_e[31:0], 3);
                        check("ldben_pulses", 32'(ldben_cnt), 1);
                        check("ldben_latency", 32'(ldben_cyc) - mon_e[31:0], 1);
                    end else begin
                        check("illegal_latency", 32'(cyc) - mon_e[31:0], 1);
                        check("illegal_busy", 32'(busy), 0);
                        check("illegal_ldben", 32'(ldben_cnt), 0);
                    end
                    ldben_cnt = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        // directed vectors: ir, pc_in, cc, expected taken, expected target
        issue(16'h0405, 16'h3001, 3'b010, 1'b1, 16'h3006); // BRz, Z set
        issue(16'h0805, 16'h3001, 3'b001, 1'b0, 16'h0000); // BRn, P set
        issue(16'h0E01, 16'hFFFF, 3'b100, 1'b1, 16'h0000); // wrap up
        issue(16'h0F00, 16'h0100, 3'b001, 1'b1, 16'h0000); // offset -256
        issue(16'h0012, 16'h4000, 3'b111, 1'b0, 16'h0000); // nzp=000 NOP
        issue(16'h03FE, 16'h3000, 3'b001, 1'b1, 16'h2FFE); // BRp, offset -2
        issue(16'h1021, 16'h3001, 3'b111, 1'b0, 16'h0000); // ADD -> illegal

        // start re-pulsed in LOAD, WAIT and RESOLVE must be ignored
        @(negedge clk);
        ir = 16'h0E10; pc_in = 16'h5000; cc = 3'b010; start = 1'b1;
        model_b = model_b + 8'd1;
        model_t = model_t + 8'd1;
        exp_q.push_back({1'b0, 1'b1, 16'h5010, model_b, model_t, 32'(cyc)});
        @(negedge clk); ir = 16'h0E20; pc_in = 16'h6000;
        @(negedge clk); ir = 16'h1021;
        @(negedge clk); ir = 16'h0E30;
        @(negedge clk); start = 1'b0;
        check("repulse_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("repulse_no_ldben", 32'(ldben), 0);
        check("repulse_no_illegal", 32'(illegal), 0);

        // reset while in WAIT
        @(negedge clk);
        ir = 16'h0E05; pc_in = 16'h7000; cc = 3'b111; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        model_b = '0;
        model_t = '0;
        @(negedge clk); reset = 1'b0;
        issue(16'h0405, 16'h3001, 3'b010, 1'b1, 16'h3006);

        // saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) begin
            issue(16'h0E01, 16'(16'h1000 + k), 3'b100, 1'b1, 16'(16'h1001 + k));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("sat_branch_count", 32'(s_branch_count), 3);
        check("sat_taken_count", 32'(s_taken_count), 3);
        check("final_branch_count", 32'(branch_count), 6);
        check("final_taken_count", 32'(taken_count), 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
